display_scanner: RTL and testbench

//   Time-multiplexes a DIGITS-wide hex value onto one shared 7-segment bus.

---
 rtl/display_scanner_if.sv | 22 ++
 rtl/display_scanner.sv | 124 ++++++++++++
 tb/tb_display_scanner.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/display_scanner_if.sv
// rtl/display_scanner_if.sv - load/value inputs and scan outputs of the display scanner
interface display_scanner_if #(
    parameter int DIGITS = 4
);
    logic                  load_i;
    logic [4*DIGITS-1:0]   value_i;
    logic [3:0]            nibble_o;
    logic [DIGITS-1:0]     digit_en_o;
    logic                  blank_o;
    logic                  pending_o;
    logic                  frame_done_o;

    modport master (
        output load_i, value_i,
        input  nibble_o, digit_en_o, blank_o, pending_o, frame_done_o
    );

    modport slave (
        input  load_i, value_i,
        output nibble_o, digit_en_o, blank_o, pending_o, frame_done_o
    );
endinterface

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - double-buffered multiplexed hex scanner for a shared 7-segment bus
module display_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD        = 2,
    parameter int BLANK_LZ    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    display_scanner_if.slave  bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int VW = 4 * DIGITS;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [PW-1:0] DEAD_P    = PW'(DEAD);
    localparam bit            HAS_DEAD  = (DEAD > 0);

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [VW-1:0]     active_q, active_d;
    logic [VW-1:0]     shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [3:0]        nibble_q, nibble_d;
    logic [DIGITS-1:0] digit_en_q, digit_en_d;
    logic              blank_q, blank_d;
    logic              frame_done_q, frame_done_d;

    logic              tick, wrap;
    logic [DIGITS-1:0] lz_vec;
    logic [DIGITS-1:0] sel_en;
    logic [3:0]        cur_nib;
    logic              cur_lz;
    logic              upper_zero;

    assign tick = (presc_q == PRESC_MAX);
    assign wrap = tick && (idx_q == IDX_MAX);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
    end

    // Same-cycle load at the frame boundary goes straight to the active buffer.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (bus.load_i && wrap) begin
            active_d  = bus.value_i;
            shadow_d  = bus.value_i;
            pending_d = 1'b0;
        end else if (wrap) begin
            if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (bus.load_i) begin
            shadow_d  = bus.value_i;
            pending_d = 1'b1;
        end
    end

    // A digit is a leading zero when it and every more-significant digit are zero.
    always_comb begin
        lz_vec     = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (active_q[4*i +: 4] == 4'h0);
            lz_vec[i]  = (BLANK_LZ != 0) && upper_zero;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_lz  = 1'b0;
        sel_en  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = active_q[4*i +: 4];
                cur_lz    = lz_vec[i];
                sel_en[i] = 1'b0;
            end
        end
        nibble_d     = cur_nib;
        blank_d      = cur_lz;
        digit_en_d   = ((HAS_DEAD && (presc_q < DEAD_P)) || cur_lz) ? '1 : sel_en;
        frame_done_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            nibble_q     <= 4'h0;
            digit_en_q   <= '1;
            blank_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            nibble_q     <= nibble_d;
            digit_en_q   <= digit_en_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.nibble_o     = nibble_q;
    assign bus.digit_en_o   = digit_en_q;
    assign bus.blank_o      = blank_q;
    assign bus.pending_o    = pending_q;
    assign bus.frame_done_o = frame_done_q;
endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - randomized bench for display_scanner against a frame-level model
module tb_display_scanner;
    localparam int D    = 4;
    localparam int RD   = 4;
    localparam int DEAD = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_scanner_if #(.DIGITS(D)) bus_lz ();
    display_scanner_if #(.DIGITS(D)) bus_all ();

    display_scanner #(.DIGITS(D), .REFRESH_DIV(RD), .DEAD(DEAD), .BLANK_LZ(1)) dut_lz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_lz)
    );

    display_scanner #(.DIGITS(D), .REFRESH_DIV(RD), .DEAD(DEAD), .BLANK_LZ(0)) dut_all (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_all)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_cnt;
    logic [15:0] m_active, m_shadow;
    logic        m_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_wrap();
        return ((m_cnt % RD) == RD - 1) && (((m_cnt / RD) % D) == D - 1);
    endfunction

    task automatic model_reset();
        m_cnt     = 0;
        m_active  = 16'h0;
        m_shadow  = 16'h0;
        m_pending = 1'b0;
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, ".lz.nibble"},   32'(bus_lz.nibble_o),      32'h0);
        check({where, ".lz.en"},       32'(bus_lz.digit_en_o),    32'hF);
        check({where, ".lz.blank"},    32'(bus_lz.blank_o),       32'h0);
        check({where, ".lz.pending"},  32'(bus_lz.pending_o),     32'h0);
        check({where, ".lz.fd"},       32'(bus_lz.frame_done_o),  32'h0);
        check({where, ".all.nibble"},  32'(bus_all.nibble_o),     32'h0);
        check({where, ".all.en"},      32'(bus_all.digit_en_o),   32'hF);
        check({where, ".all.pending"}, 32'(bus_all.pending_o),    32'h0);
    endtask

    // One clock: drive inputs, predict outputs from the pre-edge model state, then compare.
    task automatic cycle(input logic ld, input logic [15:0] v);
        int          presc, idx, digit;
        bit          wrap, lz, dark;
        logic [3:0]  en_lz, en_all;
        presc = m_cnt % RD;
        idx   = (m_cnt / RD) % D;
        wrap  = m_wrap();
        digit = int'((m_active >> (4 * idx)) & 16'hF);
        lz    = (idx > 0) && ((m_active >> (4 * idx)) == 16'h0);
        dark  = (presc < DEAD);
        en_all = 4'hF;
        if (!dark) en_all[idx] = 1'b0;
        en_lz = lz ? 4'hF : en_all;

        bus_lz.load_i   = ld;
        bus_lz.value_i  = v;
        bus_all.load_i  = ld;
        bus_all.value_i = v;

        if (ld && wrap) begin
            m_active  = v;
            m_shadow  = v;
            m_pending = 1'b0;
        end else if (wrap) begin
            if (m_pending) m_active = m_shadow;
            m_pending = 1'b0;
        end else if (ld) begin
            m_shadow  = v;
            m_pending = 1'b1;
        end
        m_cnt++;

        @(posedge clk);
        #1;
        check("lz.nibble",   32'(bus_lz.nibble_o),      32'(digit));
        check("lz.blank",    32'(bus_lz.blank_o),       32'(lz));
        check("lz.en",       32'(bus_lz.digit_en_o),    32'(en_lz));
        check("lz.fd",       32'(bus_lz.frame_done_o),  32'(wrap));
        check("lz.pending",  32'(bus_lz.pending_o),     32'(m_pending));
        check("all.nibble",  32'(bus_all.nibble_o),     32'(digit));
        check("all.blank",   32'(bus_all.blank_o),      32'h0);
        check("all.en",      32'(bus_all.digit_en_o),   32'(en_all));
        check("all.fd",      32'(bus_all.frame_done_o), 32'(wrap));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 16'h0);
    endtask

    task automatic go_to_wrap();
        for (int k = 0; k < 64 && !m_wrap(); k++) cycle(1'b0, 16'h0);
        check("wrap_reached", 32'(m_wrap()), 32'h1);
    endtask

    initial begin
        bus_lz.load_i   = 1'b0;
        bus_lz.value_i  = 16'h0;
        bus_all.load_i  = 1'b0;
        bus_all.value_i = 16'h0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        idle(40);

        idle(5);
        cycle(1'b1, 16'h1234);
        idle(40);

        idle(3);
        cycle(1'b1, 16'h0050);
        idle(40);

        go_to_wrap();
        cycle(1'b1, 16'hABCD);
        idle(36);

        go_to_wrap();
        idle(1);
        cycle(1'b1, 16'h1111);
        idle(3);
        cycle(1'b1, 16'h2222);
        idle(40);

        for (int k = 0; k < 20; k++) cycle(1'b1, 16'($urandom));
        idle(20);

        for (int k = 0; k < 600; k++) begin
            logic [15:0] v;
            v = 16'($urandom) >> (4 * $urandom_range(0, 4));
            cycle(($urandom_range(0, 7) == 0), v);
        end

        go_to_wrap();
        cycle(1'b1, 16'h9999);
        cycle(1'b1, 16'h5555);
        cycle(1'b0, 16'h0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        rst_n = 1'b1;
        model_reset();
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
